// File: rtl/alu_defs.sv
// Shared ALU definitions: datapath width, shifter opcodes and the registered result payload.
package alu_defs;

  localparam int unsigned WIDTH = 32;

  localparam logic [2:0] OP_LSR = 3'b000;
  localparam logic [2:0] OP_LSL = 3'b001;
  localparam logic [2:0] OP_ROR = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ASR = 3'b100;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             neg;
    logic             carry;
    logic             op_err;
  } res_t;

  function automatic logic is_legal_op(logic [2:0] op);
    return op <= OP_ASR;
  endfunction

endpackage

// File: rtl/shift_result_stage_if.sv
// Upstream issue and downstream writeback signals of the shift result stage.
interface shift_result_stage_if #(
  parameter int unsigned CNT_W = 16
);

  logic                       in_valid;
  logic                       in_ready;
  logic [2:0]                 op;
  logic [alu_defs::WIDTH-1:0] indata;
  logic [4:0]                 shamt;
  logic [alu_defs::WIDTH-1:0] logic_right;
  logic [alu_defs::WIDTH-1:0] logic_left;
  logic [alu_defs::WIDTH-1:0] loop_right;
  logic [alu_defs::WIDTH-1:0] loop_left;
  logic [alu_defs::WIDTH-1:0] arith_right;

  logic                       out_valid;
  logic                       out_ready;
  logic [alu_defs::WIDTH-1:0] result;
  logic                       zero;
  logic                       neg;
  logic                       carry;
  logic                       op_err;
  logic [CNT_W-1:0]           err_cnt;

  modport slave (
    input  in_valid, op, indata, shamt,
    input  logic_right, logic_left, loop_right, loop_left, arith_right,
    input  out_ready,
    output in_ready, out_valid, result, zero, neg, carry, op_err, err_cnt
  );

  modport master (
    output in_valid, op, indata, shamt,
    output logic_right, logic_left, loop_right, loop_left, arith_right,
    output out_ready,
    input  in_ready, out_valid, result, zero, neg, carry, op_err, err_cnt
  );

endinterface

// File: rtl/skid_buf2.sv
// Generic two-entry valid/ready skid buffer; main drives the outputs, spare absorbs one stall.
module skid_buf2 #(
  parameter int unsigned Width = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e           state_q, state_d;
  logic [Width-1:0] main_q, main_d;
  logic [Width-1:0] spare_q, spare_d;
  logic             in_ready_q, in_ready_d;
  logic             accept, retire;

  assign accept = in_valid_i && in_ready_q;
  assign retire = (state_q != StEmpty) && out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    spare_d = spare_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          main_d  = in_data_i;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && retire) begin
          main_d = in_data_i;
        end else if (accept) begin
          spare_d = in_data_i;
          state_d = StTwo;
        end else if (retire) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (retire) begin
          main_d  = spare_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Registered ready: depends only on the next state, never on out_ready combinationally.
    in_ready_d = (state_d != StTwo);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StEmpty;
      main_q     <= '0;
      spare_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      spare_q    <= spare_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (state_q != StEmpty);
  assign out_data_o  = main_q;

endmodule

// File: rtl/shift_result_stage.sv
// Registered result stage behind the barrel shifter: opcode select, flags, illegal-op count,
// and a two-entry skid buffer between issue and writeback.
module shift_result_stage
  import alu_defs::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input logic                 clk,
  input logic                 rst,
  shift_result_stage_if.slave bus
);

  if (WIDTH != alu_defs::WIDTH) begin : g_width_check
    $error("shift_result_stage: WIDTH must be 32");
  end

  res_t             sel;
  res_t             out_res;
  logic             carry_raw;
  logic [4:0]       lsl_idx;
  logic [4:0]       rsh_idx;
  logic             in_ready;
  logic             accept;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // 32 - shamt and shamt - 1 both fit in 5 bits for shamt in 1..31; shamt 0 masks carry.
  assign lsl_idx = 5'd0 - bus.shamt;
  assign rsh_idx = bus.shamt - 5'd1;

  always_comb begin
    sel       = '0;
    carry_raw = 1'b0;
    case (bus.op)
      OP_LSR: begin
        sel.result = bus.logic_right;
        carry_raw  = bus.indata[rsh_idx];
      end
      OP_LSL: begin
        sel.result = bus.logic_left;
        carry_raw  = bus.indata[lsl_idx];
      end
      OP_ROR: begin
        sel.result = bus.loop_right;
        carry_raw  = bus.loop_right[WIDTH-1];
      end
      OP_ROL: begin
        sel.result = bus.loop_left;
        carry_raw  = bus.loop_left[0];
      end
      OP_ASR: begin
        sel.result = bus.arith_right;
        carry_raw  = bus.indata[rsh_idx];
      end
      default: begin
        sel.op_err = 1'b1;
      end
    endcase
    sel.carry = (bus.shamt != 5'd0) && carry_raw && is_legal_op(bus.op);
    sel.zero  = (sel.result == '0);
    sel.neg   = sel.result[WIDTH-1];
  end

  assign accept = bus.in_valid && in_ready;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && sel.op_err && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  skid_buf2 #(
    .Width($bits(res_t))
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (bus.in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (sel),
    .out_valid_o(bus.out_valid),
    .out_ready_i(bus.out_ready),
    .out_data_o (out_res)
  );

  assign bus.in_ready = in_ready;
  assign bus.result   = out_res.result;
  assign bus.zero     = out_res.zero;
  assign bus.neg      = out_res.neg;
  assign bus.carry    = out_res.carry;
  assign bus.op_err   = out_res.op_err;
  assign bus.err_cnt  = err_cnt_q;

endmodule
